uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Receive-side command decoder for the acquisition board's UART links. It drains bytes from a UART RX FIFO's read port and hunts for command frames. It validates each frame's length and checksum, then emits decoded commands: a baud-word update for the UART, an ADC re-initialisation pulse, and a generic command strobe. It is the return path of the telemetry transmit path and runs in the system clock domain alongside the transmit-frame builders.

## Interface
Parameters:
- `BAUD_DEF`, 16'd8: reset value of `baud_word` (115200 baud from the 14.7456 MHz UART clock).
- `TIMEOUT_CYC`, 32'd110592: maximum clock cycles allowed between bytes inside a frame (1 ms at 110.592 MHz).

Ports:
- `clk`, in, 1: system clock, 110.592 MHz.
- `rst`, in, 1: reset, asynchronous, active-high.
- `rx_fifo_empty`, in, 1: RX FIFO empty flag.
- `rx_fifo_ren`, out, 1: RX FIFO read enable, one cycle per byte.
- `rx_fifo_rdata`, in, 8: FIFO read data, valid the cycle after `rx_fifo_ren`.
- `cmd_valid`, out, 1: one-cycle strobe when a good frame of any command code is accepted.
- `cmd_code`, out, 8: command byte of the last good frame.
- `cmd_param`, out, 32: payload of the last good frame, big-endian, right-aligned, zero-filled.
- `latch_baud`, out, 1: one-cycle strobe when a baud command is accepted.
- `baud_word`, out, 16: current baud divisor.
- `init_adc`, out, 1: one-cycle strobe when an ADC-init command is accepted.
- `cmd_err`, out, 1: one-cycle strobe on any frame error.
- `frm_cnt`, out, 16: count of good frames, wraps.
- `err_cnt`, out, 16: count of frame errors, wraps.

## Operation
- Frame layout: 0xEB, 0x90, CMD, LEN, PAYLOAD[LEN], SUM.
  - LEN is 0..4.
  - SUM is the 8-bit sum, mod 256, of CMD, LEN and the payload bytes.
- Read handshake:
  - `rx_fifo_ren` = !`rx_fifo_empty` && !`rd_pend` && state != EXEC.
  - `rd_pend` is set for exactly the cycle after a read; the byte is consumed in that cycle.
  - Maximum rate is one byte per 2 cycles.
- States:
  - HUNT0: byte 0xEB -> HUNT1; any other byte stays in HUNT0.
  - HUNT1: byte 0x90 -> CMD; byte 0xEB stays in HUNT1; any other byte -> HUNT0.
  - CMD: latch CMD, start the running sum -> LEN.
  - LEN: LEN > 4 -> error, go to HUNT0. LEN = 0 -> SUM. Otherwise -> DATA.
  - DATA: shift the byte into the 32-bit payload register, add it to the sum, decrement the remaining count; when the count reaches 0 -> SUM.
  - SUM: byte equal to the sum -> EXEC; a mismatch -> error, go to HUNT0.
  - EXEC: one cycle, no read, then -> HUNT0.
- EXEC actions:
  - Always: `cmd_valid`=1, `cmd_code`/`cmd_param` updated, `frm_cnt`+1.
  - CMD 0x01 with LEN 2: `baud_word` = payload[15:0], `latch_baud`=1.
  - CMD 0x01 with LEN != 2: counts as a good frame, but no baud update.
  - CMD 0x02: `init_adc`=1, regardless of payload.
- Error actions: `cmd_err`=1 for one cycle, `err_cnt`+1, state -> HUNT0. Header-hunt discards are not errors.
- A 0xEB arriving in CMD, LEN, DATA or SUM is treated as data, not as a resync.

## Timing
- Reset values: all strobes 0, `rx_fifo_ren` 0, `cmd_code` 0, `cmd_param` 0, `baud_word`=`BAUD_DEF`, both counters 0, state HUNT0.
- Latency: SUM byte consumed in cycle T -> `cmd_valid`/`latch_baud`/`init_adc` high in T+1. Field updates become visible in T+1.
- Error strobe: high in the cycle after the offending byte is consumed, or the cycle after a timeout expires.
- Empty FIFO: `rx_fifo_ren` stays low; no state change except the timeout counter.
- Reset mid-frame discards the partial frame; no strobe is emitted.
- Counters wrap from 0xFFFF to 0x0000.
- An error and a good frame can never occur in the same cycle.

## Configuration
- `UART_CMD_RX_TIMEOUT_EN` defined:
  - A gap counter clears on each consumed byte and increments every cycle while in CMD, LEN, DATA or SUM.
  - When the counter reaches `TIMEOUT_CYC`, the frame is treated as an error and the state returns to HUNT0.
- Not defined: no gap counter. A partial frame waits indefinitely, and `TIMEOUT_CYC` is ignored.

## Test plan
- Baud command: feed EB 90 01 02 00 10 13 -> `latch_baud` pulses once, `baud_word`=0x0010, `cmd_code`=0x01, `frm_cnt`=1.
- ADC init with resync: feed EB EB 90 02 00 02 -> `init_adc` pulses once, `cmd_valid`=1, `cmd_err` stays 0.
- Generic command: feed EB 90 05 04 11 22 33 44 B3 -> `cmd_param`=0x11223344, `cmd_code`=0x05, `cmd_valid` one cycle.
- Bad checksum: feed EB 90 01 02 00 10 14 -> `cmd_err` pulses, `err_cnt`=1, `baud_word` unchanged.
- Bad length: feed EB 90 03 05 -> `cmd_err` pulses. Then feed EB 90 02 00 02 -> `init_adc` pulses.
- Timeout (macro defined): feed EB 90 01, then idle `TIMEOUT_CYC` cycles -> `cmd_err`=1, `err_cnt`+1. Then a good frame decodes normally.
- Reset mid-frame: assert `rst` after EB 90 01 -> no strobes, `baud_word`=`BAUD_DEF`.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: drains a UART RX FIFO, hunts for EB 90 command frames, validates LEN/SUM and decodes commands.
// Optional inter-byte timeout is compiled in when UART_CMD_RX_TIMEOUT_EN is defined.
module uart_cmd_rx #(
  parameter logic [15:0] BAUD_DEF    = 16'd8,
  parameter logic [31:0] TIMEOUT_CYC = 32'd110592
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_ren,
  input  logic [7:0]  rx_fifo_rdata,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [31:0] cmd_param,
  output logic        latch_baud,
  output logic [15:0] baud_word,
  output logic        init_adc,
  output logic        cmd_err,
  output logic [15:0] frm_cnt,
  output logic [15:0] err_cnt
);
  localparam int unsigned PAY_W = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [7:0]  SYNC0    = 8'hEB;
  localparam logic [7:0]  SYNC1    = 8'h90;
  localparam logic [7:0]  CMD_BAUD = 8'h01;
  localparam logic [7:0]  CMD_ADC  = 8'h02;
  localparam logic [7:0]  MAX_LEN  = 8'd4;

  typedef enum logic [2:0] {
    S_HUNT0, S_HUNT1, S_CMD, S_LEN, S_DATA, S_SUM, S_EXEC
  } state_t;

  state_t             state_q, state_d;
  logic               rd_pend_q;
  logic [7:0]         code_q, code_d;
  logic [2:0]         len_q, len_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [7:0]         sum_q, sum_d;
  logic [PAY_W-1:0]   pay_q, pay_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [7:0]         cmd_code_q, cmd_code_d;
  logic [PAY_W-1:0]   cmd_param_q, cmd_param_d;
  logic               latch_baud_q, latch_baud_d;
  logic [15:0]        baud_q, baud_d;
  logic               init_adc_q, init_adc_d;
  logic               cmd_err_q, cmd_err_d;
  logic [CNT_W-1:0]   frm_cnt_q, frm_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               in_frame_c;
  logic               timeout_c;

  assign in_frame_c  = (state_q == S_CMD) || (state_q == S_LEN) ||
                       (state_q == S_DATA) || (state_q == S_SUM);
  assign rx_fifo_ren = !rx_fifo_empty && !rd_pend_q && (state_q != S_EXEC);

`ifdef UART_CMD_RX_TIMEOUT_EN
  // Gap counter: cycles since the last consumed byte while a frame is open.
  logic [31:0] gap_q, gap_d;
  assign gap_d     = (in_frame_c && !rd_pend_q) ? gap_q + 32'd1 : 32'd0;
  assign timeout_c = in_frame_c && !rd_pend_q && (gap_q == TIMEOUT_CYC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end
`else
  // Partial frames wait forever; TIMEOUT_CYC has no effect in this build.
  assign timeout_c = 1'b0 & (TIMEOUT_CYC != 32'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_HUNT0;
      rd_pend_q    <= 1'b0;
      code_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      pay_q        <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= '0;
      cmd_param_q  <= '0;
      latch_baud_q <= 1'b0;
      baud_q       <= BAUD_DEF;
      init_adc_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      frm_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_pend_q    <= rx_fifo_ren;
      code_q       <= code_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      pay_q        <= pay_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      cmd_param_q  <= cmd_param_d;
      latch_baud_q <= latch_baud_d;
      baud_q       <= baud_d;
      init_adc_q   <= init_adc_d;
      cmd_err_q    <= cmd_err_d;
      frm_cnt_q    <= frm_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    logic good, bad;
    state_d      = state_q;
    code_d       = code_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    pay_d        = pay_q;
    cmd_valid_d  = 1'b0;
    cmd_code_d   = cmd_code_q;
    cmd_param_d  = cmd_param_q;
    latch_baud_d = 1'b0;
    baud_d       = baud_q;
    init_adc_d   = 1'b0;
    cmd_err_d    = 1'b0;
    frm_cnt_d    = frm_cnt_q;
    err_cnt_d    = err_cnt_q;
    good         = 1'b0;
    bad          = timeout_c;

    // A byte is consumed in the cycle after its read (rd_pend_q).
    case (state_q)
      S_HUNT0: if (rd_pend_q && rx_fifo_rdata == SYNC0) state_d = S_HUNT1;
      S_HUNT1: if (rd_pend_q) begin
        if (rx_fifo_rdata == SYNC1)      state_d = S_CMD;
        else if (rx_fifo_rdata != SYNC0) state_d = S_HUNT0;
      end
      S_CMD: if (rd_pend_q) begin
        code_d  = rx_fifo_rdata;
        sum_d   = rx_fifo_rdata;
        pay_d   = '0;
        state_d = S_LEN;
      end
      S_LEN: if (rd_pend_q) begin
        sum_d = sum_q + rx_fifo_rdata;
        len_d = rx_fifo_rdata[2:0];
        cnt_d = rx_fifo_rdata[2:0];
        if (rx_fifo_rdata > MAX_LEN)     bad = 1'b1;
        else if (rx_fifo_rdata == 8'd0)  state_d = S_SUM;
        else                             state_d = S_DATA;
      end
      S_DATA: if (rd_pend_q) begin
        pay_d = {pay_q[PAY_W-9:0], rx_fifo_rdata};
        sum_d = sum_q + rx_fifo_rdata;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_SUM;
      end
      S_SUM: if (rd_pend_q) begin
        if (rx_fifo_rdata == sum_q) begin
          good    = 1'b1;
          state_d = S_EXEC;
        end else begin
          bad = 1'b1;
        end
      end
      S_EXEC:  state_d = S_HUNT0;
      default: state_d = S_HUNT0;
    endcase

    if (bad) begin
      state_d   = S_HUNT0;
      cmd_err_d = 1'b1;
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    if (good) begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = code_q;
      cmd_param_d = pay_q;
      frm_cnt_d   = frm_cnt_q + CNT_W'(1);
      if (code_q == CMD_BAUD && len_q == 3'd2) begin
        baud_d       = pay_q[15:0];
        latch_baud_d = 1'b1;
      end
      if (code_q == CMD_ADC) init_adc_d = 1'b1;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_param  = cmd_param_q;
  assign latch_baud = latch_baud_q;
  assign baud_word  = baud_q;
  assign init_adc   = init_adc_q;
  assign cmd_err    = cmd_err_q;
  assign frm_cnt    = frm_cnt_q;
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed frames into a bench FIFO, checked every cycle against a queue-based frame model.
// Honours UART_CMD_RX_TIMEOUT_EN for the inter-byte timeout scenario.
module tb_uart_cmd_rx;
  localparam logic [15:0] BAUD_DEF = 16'd8;
  localparam int          TO       = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_fifo_empty = 1'b1;
  logic        rx_fifo_ren;
  logic [7:0]  rx_fifo_rdata = 8'h00;
  logic        cmd_valid, latch_baud, init_adc, cmd_err;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_param;
  logic [15:0] baud_word, frm_cnt, err_cnt;

  uart_cmd_rx #(.BAUD_DEF(BAUD_DEF), .TIMEOUT_CYC(32'(TO))) dut (
    .clk(clk), .rst(rst), .rx_fifo_empty(rx_fifo_empty), .rx_fifo_ren(rx_fifo_ren),
    .rx_fifo_rdata(rx_fifo_rdata), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_param(cmd_param), .latch_baud(latch_baud), .baud_word(baud_word),
    .init_adc(init_adc), .cmd_err(cmd_err), .frm_cnt(frm_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, last_c = 0;
  logic [7:0] fifo[$];
  logic [7:0] fr[$];
  logic [7:0] mq[$];
  logic       pend_v = 1'b0;
  logic [7:0] pend_b = 8'h00;
  logic        e_valid, e_latch, e_init, e_err;
  logic [7:0]  e_code;
  logic [31:0] e_param;
  logic [15:0] e_baud, e_frm, e_errcnt;
  int n_valid, n_latch, n_init, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_valid = 0; e_latch = 0; e_init = 0; e_err = 0;
    e_code = 0; e_param = 0; e_baud = BAUD_DEF; e_frm = 0; e_errcnt = 0;
  endtask

  task automatic frame_err();
    e_err = 1;
    e_errcnt = e_errcnt + 16'd1;
    mq.delete();
  endtask

  // Frame-level model: collect candidate bytes, judge the frame once LEN says it is complete.
  task automatic model_byte(input logic [7:0] b);
    int n;
    logic [7:0]  s;
    logic [31:0] p;
    mq.push_back(b);
    n = mq.size();
    if (n == 1) begin
      if (b != 8'hEB) mq.delete();
    end else if (n == 2) begin
      if (b == 8'hEB) begin mq.delete(); mq.push_back(8'hEB); end
      else if (b != 8'h90) mq.delete();
    end else if (n == 4 && b > 8'd4) begin
      frame_err();
    end else if (n >= 5 && n == 5 + int'(mq[3])) begin
      s = 0; p = 0;
      for (int i = 2; i <= n - 2; i++) s = s + mq[i];
      for (int i = 4; i <= n - 2; i++) p = {p[23:0], mq[i]};
      if (mq[n-1] == s) begin
        e_valid = 1; e_code = mq[2]; e_param = p; e_frm = e_frm + 16'd1;
        if (mq[2] == 8'h01 && mq[3] == 8'd2) begin e_baud = p[15:0]; e_latch = 1; end
        if (mq[2] == 8'h02) e_init = 1;
        mq.delete();
      end else begin
        frame_err();
      end
    end
  endtask

  // One clock cycle: compare, advance the model, serve the FIFO read port.
  task automatic step();
    logic pend_prev, cur_valid;
    @(negedge clk);
    cyc++;
    chk("cmd_valid", 32'(cmd_valid), 32'(e_valid));
    chk("latch_baud", 32'(latch_baud), 32'(e_latch));
    chk("init_adc", 32'(init_adc), 32'(e_init));
    chk("cmd_err", 32'(cmd_err), 32'(e_err));
    chk("cmd_code", 32'(cmd_code), 32'(e_code));
    chk("cmd_param", cmd_param, e_param);
    chk("baud_word", 32'(baud_word), 32'(e_baud));
    chk("frm_cnt", 32'(frm_cnt), 32'(e_frm));
    chk("err_cnt", 32'(err_cnt), 32'(e_errcnt));
    n_valid += int'(cmd_valid); n_latch += int'(latch_baud);
    n_init  += int'(init_adc);  n_err   += int'(cmd_err);
    pend_prev = pend_v;
    cur_valid = e_valid;
    e_valid = 0; e_latch = 0; e_init = 0; e_err = 0;
    if (!rst) begin
      if (pend_v) begin
        model_byte(pend_b);
        last_c = cyc;
      end
`ifdef UART_CMD_RX_TIMEOUT_EN
      else if (mq.size() >= 2 && cyc + 1 == last_c + TO + 2) frame_err();
`endif
    end
    pend_v = 0;
    rx_fifo_empty = (fifo.size() == 0);
    #1;
    if (!rst) begin
      chk("rx_fifo_ren", 32'(rx_fifo_ren), 32'(!rx_fifo_empty && !pend_prev && !cur_valid));
      if (rx_fifo_ren) begin
        rx_fifo_rdata = fifo.pop_front();
        pend_b = rx_fifo_rdata;
        pend_v = 1;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1;
    fifo.delete();
    pend_v = 0;
    model_reset();
    repeat (3) step();
    rst = 0;
  endtask

  task automatic send();
    int guard;
    foreach (fr[i]) fifo.push_back(fr[i]);
    guard = 0;
    while ((fifo.size() != 0 || pend_v) && guard < 100) begin step(); guard++; end
    chk("drain_bound", 32'(guard < 100), 32'd1);
    repeat (4) step();
  endtask

  task automatic clr_pulses();
    n_valid = 0; n_latch = 0; n_init = 0; n_err = 0;
  endtask

  initial begin
    clr_pulses();
    apply_reset();
    chk("reset_baud", 32'(baud_word), 32'h0008);
    chk("reset_cnts", {frm_cnt, err_cnt}, 32'h0);

    clr_pulses(); fr = {8'hEB, 8'h90, 8'h01, 8'h02, 8'h00, 8'h10, 8'h13}; send();
    chk("baud_latch_pulses", 32'(n_latch), 32'd1);
    chk("baud_word_0010", 32'(baud_word), 32'h0010);
    chk("baud_code", 32'(cmd_code), 32'h01);
    chk("baud_frm_cnt", 32'(frm_cnt), 32'd1);

    clr_pulses(); fr = {8'hEB, 8'hEB, 8'h90, 8'h02, 8'h00, 8'h02}; send();
    chk("adc_init_pulses", 32'(n_init), 32'd1);
    chk("adc_valid_pulses", 32'(n_valid), 32'd1);
    chk("adc_no_err", 32'(n_err), 32'd0);

    clr_pulses(); fr = {8'hEB, 8'h90, 8'h05, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hB3}; send();
    chk("gen_param", cmd_param, 32'h11223344);
    chk("gen_code", 32'(cmd_code), 32'h05);
    chk("gen_valid_pulses", 32'(n_valid), 32'd1);

    clr_pulses(); fr = {8'hEB, 8'h90, 8'h01, 8'h02, 8'h00, 8'h10, 8'h14}; send();
    chk("badsum_err_pulses", 32'(n_err), 32'd1);
    chk("badsum_err_cnt", 32'(err_cnt), 32'd1);
    chk("badsum_baud_kept", 32'(baud_word), 32'h0010);

    clr_pulses(); fr = {8'hEB, 8'h90, 8'h03, 8'h05}; send();
    chk("badlen_err_pulses", 32'(n_err), 32'd1);
    clr_pulses(); fr = {8'hEB, 8'h90, 8'h02, 8'h00, 8'h02}; send();
    chk("after_badlen_init", 32'(n_init), 32'd1);
    chk("after_badlen_err_cnt", 32'(err_cnt), 32'd2);

    clr_pulses(); fr = {8'hEB, 8'h90, 8'h01, 8'h01, 8'h20, 8'h22}; send();
    chk("baud_len1_no_latch", 32'(n_latch), 32'd0);
    chk("baud_len1_valid", 32'(n_valid), 32'd1);
    chk("baud_len1_baud_kept", 32'(baud_word), 32'h0010);

    clr_pulses(); fr = {8'h55, 8'hAA, 8'hEB, 8'h90, 8'h07, 8'h01, 8'hEB, 8'hF3}; send();
    chk("eb_as_data_param", cmd_param, 32'h000000EB);
    chk("eb_as_data_frm_cnt", 32'(frm_cnt), 32'd6);

    clr_pulses(); fr = {8'hEB, 8'h90, 8'h01}; send();
    repeat (200) step();
`ifdef UART_CMD_RX_TIMEOUT_EN
    chk("timeout_err_pulses", 32'(n_err), 32'd1);
    chk("timeout_err_cnt", 32'(err_cnt), 32'd3);
    fr = {8'hEB, 8'h90, 8'h01, 8'h02, 8'h00, 8'h20, 8'h23}; send();
`else
    chk("no_timeout_err_pulses", 32'(n_err), 32'd0);
    chk("no_timeout_err_cnt", 32'(err_cnt), 32'd2);
    fr = {8'h02, 8'h00, 8'h20, 8'h23}; send();
`endif
    chk("late_frame_baud", 32'(baud_word), 32'h0020);
    chk("late_frame_frm_cnt", 32'(frm_cnt), 32'd7);

    clr_pulses(); fr = {8'hEB, 8'h90, 8'h01}; send();
    apply_reset();
    repeat (5) step();
    chk("midreset_no_strobes", 32'(n_valid + n_latch + n_init + n_err), 32'd0);
    chk("midreset_baud", 32'(baud_word), 32'(BAUD_DEF));
    chk("midreset_cnts", {frm_cnt, err_cnt}, 32'h0);
    clr_pulses(); fr = {8'hEB, 8'h90, 8'h02, 8'h00, 8'h02}; send();
    chk("post_reset_init", 32'(n_init), 32'd1);
    chk("post_reset_frm_cnt", 32'(frm_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
